motoro3_pwm_multich: RTL and testbench

N-channel, parametrised successor to the single-channel motor PWM generator. It runs one shared period counter. Each channel turns a per-period on-time request into pulses, with three rules:
- a minimum-pulse limit;
- remainder carry: skipped or excess time rolls into later periods;
- edge- or center-aligned placement.
Per-segment want-vs-real accounting gives the commutation controller a "lost" value for each channel. The block sits between the step sequencer (segment first/last strobes) and the MOS gate drivers.

---
 rtl/motoro3_pwm_multich.sv | 143 ++++++++++++++
 tb/tb_motoro3_pwm_multich.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_pwm_multich.sv
// Multi-channel motor PWM generator: one shared period counter, per-channel minimum-pulse
// gating with remainder carry, edge/center placement and per-segment want-vs-real accounting.
module motoro3_pwm_multich #(
   parameter int unsigned CH = 3,
   parameter int unsigned CW = 12,
   parameter int unsigned AW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              seg_first,
   input  logic              seg_last,
   input  logic [CW-1:0]     period_len,
   input  logic [CW-1:0]     min_pulse,
   input  logic              center_mode,
   input  logic [CH-1:0]     pol,
   input  logic [CH*AW-1:0]  duty_req,
   output logic [CH-1:0]     pwm_out,
   output logic              period_tick,
   output logic [CH*AW-1:0]  lost,
   output logic              lost_valid
);

   localparam logic [CW-1:0] LEN_MIN = CW'(2);

   logic [CW-1:0] len_c;
   logic [CW-1:0] pcnt_q, pcnt_d;
   logic          reload_c, ch_load_c;
   logic          tick_q, lv_q;

   // A period shorter than two clocks would leave no room for the reload cycle.
   assign len_c     = (period_len < LEN_MIN) ? LEN_MIN : period_len;
   assign reload_c  = en & ~seg_last & (pcnt_q == CW'(1));
   assign ch_load_c = reload_c & ~seg_first;

   always_comb begin
      pcnt_d = pcnt_q - CW'(1);
      if (!en || seg_last || (pcnt_q == CW'(1))) begin
         pcnt_d = len_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q <= len_c;
         tick_q <= 1'b0;
         lv_q   <= 1'b0;
      end else begin
         pcnt_q <= pcnt_d;
         tick_q <= reload_c;
         lv_q   <= en & seg_last;
      end
   end

   assign period_tick = tick_q;
   assign lost_valid  = lv_q;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [AW-1:0] duty_c, sat_c, pulse_c;
      logic [AW:0]   sum_c;
      logic [AW-1:0] rem_q, rem_d, pc_q, pc_d;
      logic [AW-1:0] want_q, want_d, got_q, got_d, lost_q, lost_d;
      logic [CW-1:0] dly_q, dly_d;
      logic          act_c, act_nxt_c, pwm_q;

      // Carry plus request saturates instead of wrapping so a huge backlog never turns small.
      assign duty_c    = duty_req[c*AW +: AW];
      assign sum_c     = {1'b0, rem_q} + {1'b0, duty_c};
      assign sat_c     = sum_c[AW] ? {AW{1'b1}} : sum_c[AW-1:0];
      assign pulse_c   = (sat_c > AW'(len_c)) ? AW'(len_c) : sat_c;
      assign act_c     = (dly_q == '0) && (pc_q != '0);
      assign act_nxt_c = (dly_d == '0) && (pc_d != '0);

      always_comb begin
         rem_d  = rem_q;
         pc_d   = pc_q;
         dly_d  = dly_q;
         want_d = want_q;
         got_d  = got_q;
         lost_d = lost_q;
         if (!en) begin
            pc_d   = '0;
            dly_d  = '0;
            rem_d  = '0;
            want_d = '0;
            got_d  = '0;
         end else if (seg_last) begin
            pc_d   = '0;
            dly_d  = '0;
            lost_d = want_q - got_q;
            want_d = '0;
            got_d  = '0;
         end else begin
            got_d = got_q + AW'(act_c);
            if (dly_q != '0) begin
               dly_d = dly_q - CW'(1);
            end else if (pc_q != '0) begin
               pc_d = pc_q - AW'(1);
            end
            if (seg_first) begin
               rem_d  = '0;
               want_d = '0;
               got_d  = '0;
            end else if (ch_load_c) begin
               want_d = want_q + duty_c;
               if (sat_c < AW'(min_pulse)) begin
                  pc_d  = '0;
                  dly_d = '0;
                  rem_d = sat_c;
               end else begin
                  pc_d  = pulse_c;
                  rem_d = sat_c - pulse_c;
                  dly_d = center_mode ? CW'((AW'(len_c) - pulse_c) >> 1) : '0;
               end
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rem_q  <= '0;
            pc_q   <= '0;
            dly_q  <= '0;
            want_q <= '0;
            got_q  <= '0;
            lost_q <= '0;
            pwm_q  <= pol[c];
         end else begin
            rem_q  <= rem_d;
            pc_q   <= pc_d;
            dly_q  <= dly_d;
            want_q <= want_d;
            got_q  <= got_d;
            lost_q <= lost_d;
            pwm_q  <= act_nxt_c ^ pol[c];
         end
      end

      assign pwm_out[c]         = pwm_q;
      assign lost[c*AW +: AW]   = lost_q;
   end

endmodule

// File: tb/tb_motoro3_pwm_multich.sv
// Bench for motoro3_pwm_multich: an interval-based reference model predicts every output
// cycle into a queue that a separate monitor drains, plus directed waveform checks.
module tb_motoro3_pwm_multich;

   localparam int unsigned CH = 3;
   localparam int unsigned CW = 12;
   localparam int unsigned AW = 16;
   localparam longint      SAT = (longint'(1) << AW) - 1;

   logic              clk, rst, en, seg_first, seg_last, center_mode;
   logic [CW-1:0]     period_len, min_pulse;
   logic [CH-1:0]     pol, pwm_out;
   logic [CH*AW-1:0]  duty_req, lost;
   logic              period_tick, lost_valid;

   typedef struct packed {
      logic [CH-1:0]    pwm;
      logic             tick;
      logic             lv;
      logic [CH*AW-1:0] lost;
   } obs_t;

   obs_t   exp_q[$];
   int     errors = 0;
   int     checks = 0;
   int     meas_cnt[CH];
   int     meas_first[CH];

   // Reference model: absolute cycle numbers, pulses as [start,end] cycle intervals.
   longint        m_t = 0;
   longint        m_next = -1;
   int            m_reloads = 0;
   logic [AW-1:0] m_rem[CH], m_want[CH], m_got[CH], m_lost[CH];
   longint        m_st[CH], m_end[CH];

   motoro3_pwm_multich #(.CH(CH), .CW(CW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .en(en), .seg_first(seg_first), .seg_last(seg_last),
      .period_len(period_len), .min_pulse(min_pulse), .center_mode(center_mode),
      .pol(pol), .duty_req(duty_req), .pwm_out(pwm_out), .period_tick(period_tick),
      .lost(lost), .lost_valid(lost_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit m_act(input int c, input longint t);
      return (t >= m_st[c]) && (t <= m_end[c]);
   endfunction

   function automatic logic [CH*AW-1:0] pack3(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                             input logic [AW-1:0] c);
      return {c, b, a};
   endfunction

   initial begin
      for (int c = 0; c < CH; c++) begin
         m_st[c] = 1; m_end[c] = 0;
         m_rem[c] = '0; m_want[c] = '0; m_got[c] = '0; m_lost[c] = '0;
      end
   end

   always @(posedge clk) begin : model
      longint        len, sum, p, d;
      bit            rl;
      logic [AW-1:0] duty;
      obs_t          e;
      len = (period_len < 2) ? 2 : longint'(period_len);
      rl  = en && !seg_last && (m_t == m_next);
      if (rst) begin
         m_next = m_t + len;
         for (int c = 0; c < CH; c++) begin
            m_rem[c] = '0; m_want[c] = '0; m_got[c] = '0; m_lost[c] = '0;
            m_st[c] = 1; m_end[c] = 0;
         end
      end else if (!en) begin
         m_next = m_t + len;
         for (int c = 0; c < CH; c++) begin
            m_rem[c] = '0; m_want[c] = '0; m_got[c] = '0;
            m_st[c] = 1; m_end[c] = 0;
         end
      end else if (seg_last) begin
         m_next = m_t + len;
         for (int c = 0; c < CH; c++) begin
            m_lost[c] = m_want[c] - m_got[c];
            m_want[c] = '0; m_got[c] = '0;
            m_st[c] = 1; m_end[c] = 0;
         end
      end else begin
         if (m_t == m_next) m_next = m_t + len;
         for (int c = 0; c < CH; c++) m_got[c] = m_got[c] + AW'(m_act(c, m_t));
         if (seg_first) begin
            for (int c = 0; c < CH; c++) begin
               m_rem[c] = '0; m_want[c] = '0; m_got[c] = '0;
            end
         end else if (rl) begin
            m_reloads++;
            for (int c = 0; c < CH; c++) begin
               duty = duty_req[c*AW +: AW];
               m_want[c] = m_want[c] + duty;
               sum = longint'(m_rem[c]) + longint'(duty);
               if (sum > SAT) sum = SAT;
               if (sum < longint'(min_pulse)) begin
                  m_rem[c] = AW'(sum);
                  m_st[c] = 1; m_end[c] = 0;
               end else begin
                  p = (sum < len) ? sum : len;
                  m_rem[c] = AW'(sum - p);
                  d = center_mode ? (len - p) / 2 : 0;
                  m_st[c]  = m_t + 1 + d;
                  m_end[c] = m_t + d + p;
               end
            end
         end
      end
      e.tick = rl && !rst;
      e.lv   = !rst && en && seg_last;
      for (int c = 0; c < CH; c++) begin
         e.pwm[c] = m_act(c, m_t + 1) ^ pol[c];
         e.lost[c*AW +: AW] = m_lost[c];
      end
      exp_q.push_back(e);
      m_t++;
   end

   always @(negedge clk) begin : monitor
      obs_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.pwm = pwm_out; a.tick = period_tick; a.lv = lost_valid; a.lost = lost;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t: got pwm=%b tick=%b lv=%b lost=%h, expected pwm=%b tick=%b lv=%b lost=%h",
                     $time, a.pwm, a.tick, a.lv, a.lost, e.pwm, e.tick, e.lv, e.lost);
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      @(negedge clk);
      while (!period_tick && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("wait_period_tick", longint'(period_tick), 1);
   endtask

   // Counts active (polarity-corrected) cycles per channel starting at the current cycle.
   task automatic measure(input int len);
      for (int c = 0; c < CH; c++) begin
         meas_cnt[c] = 0; meas_first[c] = -1;
      end
      for (int k = 0; k < len; k++) begin
         for (int c = 0; c < CH; c++) begin
            if (pwm_out[c] ^ pol[c]) begin
               meas_cnt[c]++;
               if (meas_first[c] < 0) meas_first[c] = k;
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin : stim
      int n, base;
      rst = 1'b1; en = 1'b0; seg_first = 1'b0; seg_last = 1'b0; center_mode = 1'b0;
      pol = '0; period_len = CW'(100); min_pulse = CW'(16);
      duty_req = pack3(16'd20, 16'd50, 16'd100);
      repeat (3) @(negedge clk);
      chk("reset_pwm", longint'(pwm_out), 0);
      chk("reset_tick", longint'(period_tick), 0);
      chk("reset_lost_valid", longint'(lost_valid), 0);
      chk("reset_lost", longint'(lost), 0);
      rst = 1'b0; en = 1'b1;

      // Edge-aligned widths 20/50/100
      wait_tick(); wait_tick();
      measure(100);
      chk("edge_w0", meas_cnt[0], 20);
      chk("edge_w1", meas_cnt[1], 50);
      chk("edge_w2", meas_cnt[2], 100);
      chk("edge_start0", meas_first[0], 0);

      // Below-minimum requests carry into a pulse every second period
      duty_req = pack3(16'd10, 16'd10, 16'd10);
      wait_tick(); wait_tick();
      measure(200);
      for (int c = 0; c < CH; c++) chk($sformatf("carry_w%0d", c), meas_cnt[c], 20);

      // Segment accounting: 5 reloads of 20, seg_last after 12 active clocks
      duty_req = pack3(16'd20, 16'd20, 16'd20);
      wait_tick(); wait_tick();
      n = 0;
      while ((m_next - m_t) != 10 && n < 300) begin
         @(negedge clk);
         n++;
      end
      seg_first = 1'b1;
      @(negedge clk);
      seg_first = 1'b0;
      base = m_reloads;
      n = 0;
      while (m_reloads < base + 5 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (12) @(negedge clk);
      seg_last = 1'b1;
      @(negedge clk);
      seg_last = 1'b0;
      chk("seg_lost_valid", longint'(lost_valid), 1);
      for (int c = 0; c < CH; c++) chk($sformatf("seg_lost%0d", c), longint'(lost[c*AW +: AW]), 8);
      chk("seg_pwm_off", longint'(pwm_out), 0);

      // Center-aligned, then inverted polarity
      center_mode = 1'b1;
      duty_req = pack3(16'd40, 16'd40, 16'd40);
      wait_tick(); wait_tick();
      measure(100);
      chk("center_first0", meas_first[0], 30);
      chk("center_w0", meas_cnt[0], 40);
      pol = 3'b111;
      wait_tick();
      chk("center_inv_idle", longint'(pwm_out), 7);
      measure(100);
      chk("center_inv_first1", meas_first[1], 30);
      chk("center_inv_w1", meas_cnt[1], 40);

      // Excess carry, then saturation at a short period
      pol = '0; center_mode = 1'b0;
      duty_req = pack3(16'd150, 16'd150, 16'd150);
      wait_tick(); wait_tick();
      measure(100);
      chk("excess_w0", meas_cnt[0], 100);
      period_len = CW'(3);
      duty_req = pack3(16'hFFF0, 16'hFFF0, 16'hFFF0);
      repeat (20) @(negedge clk);
      duty_req = '0;
      repeat (30) @(negedge clk);
      measure(30);
      chk("sat_backlog_w0", meas_cnt[0], 30);

      // Reset mid-pulse, then reset with period_len=0
      period_len = CW'(100);
      duty_req = pack3(16'd50, 16'd50, 16'd50);
      pol = 3'b101;
      wait_tick(); wait_tick();
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_pwm_pol", longint'(pwm_out), 5);
      chk("rst_lost", longint'(lost), 0);
      period_len = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("len0_tick_a", longint'(period_tick), 0);
      @(negedge clk);
      chk("len0_tick_b", longint'(period_tick), 1);
      @(negedge clk);
      chk("len0_tick_c", longint'(period_tick), 0);
      @(negedge clk);
      chk("len0_tick_d", longint'(period_tick), 1);

      // Randomized traffic
      period_len = CW'(20); min_pulse = CW'(4); pol = '0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 49) == 0) period_len = CW'($urandom_range(0, 40));
         if ($urandom_range(0, 49) == 0) min_pulse = CW'($urandom_range(0, 20));
         if ($urandom_range(0, 29) == 0) begin
            for (int c = 0; c < CH; c++)
               duty_req[c*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'(16'hFF00 + $urandom_range(0, 255))
                                                                 : AW'($urandom_range(0, 50));
         end
         if ($urandom_range(0, 99) == 0) center_mode = ~center_mode;
         if ($urandom_range(0, 199) == 0) pol = CH'($urandom_range(0, 7));
         en        = ($urandom_range(0, 99) != 0);
         rst       = ($urandom_range(0, 499) == 0);
         seg_last  = ($urandom_range(0, 79) == 0);
         seg_first = ($urandom_range(0, 79) == 0) && (m_t != m_next);
      end
      @(negedge clk);
      rst = 1'b0; en = 1'b0; seg_first = 1'b0; seg_last = 1'b0;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
